mig_user_bridge: RTL and testbench
==================================

# mig_user_bridge

Converts single cache-line read/write requests from the memory-side cache controller into the MIG user-interface command/write-data handshake, and returns read data to the client. Sits directly upstream of the MIG 7-series controller, or its simulation model. It is the only block that drives `app_*`. It holds one outstanding transaction, enforces a command gap, and reports a read timeout.

## Interface

**Parameters**
- `DATA_WIDTH`, default `` `WDFP ``: line width in bits, equal to the MIG data width.
- `TIMEOUT`, default 1024: cycles allowed from read-command acceptance to `app_rd_data_valid`.

**Ports** (all MIG-side names match the controller's)
- `clk_i`, in, 1: the single clock. All logic is in this domain.
- `rst_ni`, in, 1: asynchronous reset, active-low.
- `req_i`, in, 1: request strobe. Sampled only while `ready_o` = 1.
- `we_i`, in, 1: 1 = write, 0 = read.
- `addr_i`, in, 32: byte address.
- `wdata_i`, in, `DATA_WIDTH`: write line.
- `be_i`, in, `DATA_WIDTH/8`: byte enables, 1 = write the byte.
- `ready_o`, out, 1: bridge is idle and will accept `req_i`.
- `rdata_o`, out, `DATA_WIDTH`: last read line. Held until the next read completes.
- `done_o`, out, 1: one-cycle completion pulse.
- `err_o`, out, 1: read timed out. Valid only with `done_o`.
- `app_en`, out, 1.
- `app_addr`, out, 28.
- `app_cmd`, out, 3.
- `app_wdf_data`, out, `DATA_WIDTH`.
- `app_wdf_mask`, out, `DATA_WIDTH/8`: 1 = keep the byte.
- `app_wdf_wren`, out, 1.
- `app_wdf_end`, out, 1.
- `app_rdy`, in, 1.
- `app_wdf_rdy`, in, 1.
- `app_rd_data`, in, `DATA_WIDTH`.
- `app_rd_data_valid`, in, 1.
- `app_rd_data_end`, in, 1: ignored.
- `app_sr_req`, `app_ref_req`, `app_zq_req`, out, 1 each: tied to 0.

## Operation

**States:** IDLE, CMD, RD_WAIT, DONE.

**IDLE**
- `ready_o` = 1.
- On `req_i` = 1, register `we_i`, `addr_i`, `wdata_i` and `be_i`, then go to CMD.
- Address mapping: `app_addr` = {`addr_i[30:6]`, 3'b000}. The address is burst-aligned and bits [5:0] are dropped.
- `app_cmd` = 3'b000 for a write, 3'b001 for a read.
- `app_wdf_mask` = ~`be_i` as registered.

**CMD**
- `app_en` = 1 until the command is accepted. Acceptance is a rising edge with `app_en` & `app_rdy` both 1.
- Read: on acceptance, go to RD_WAIT and clear the timeout counter.
- Write: `app_wdf_wren` = `app_wdf_end` = 1 until the data is accepted. Data acceptance is a rising edge with `app_wdf_wren` & `app_wdf_rdy` both 1.
- Command and data acceptance are tracked by two independent flags. Either may occur first, or both in the same cycle.
- Each signal drops in the cycle after its own acceptance.
- Go to DONE once both flags are set.

**RD_WAIT**
- `app_en` = 0.
- On `app_rd_data_valid`: latch `app_rd_data` into `rdata_o` and go to DONE with `err_o` = 0.
- On the counter reaching `TIMEOUT`-1 without valid: go to DONE with `err_o` = 1. `rdata_o` keeps its previous value.

**DONE**
- `done_o` = 1 for exactly this one cycle.
- `app_en` = 0 and `ready_o` = 0.
- Next state is IDLE. This guarantees `app_en` is low for at least 2 cycles between commands.

**Boundary rules**
- `app_rd_data_valid` outside RD_WAIT is discarded: no latch, no state change.
- `req_i` outside IDLE is ignored. The client must wait for `ready_o`.
- If valid and timeout coincide, valid wins (`err_o` = 0).
- A timeout counter at `TIMEOUT`-1 never wraps, because the state leaves RD_WAIT.

## Timing

**Reset values**
- State IDLE.
- `ready_o` = 1.
- All other outputs are 0, including `rdata_o` and `app_addr`.
- An `rst_ni` assertion mid-transaction drops `app_en` and `app_wdf_wren` immediately (asynchronous) and abandons the transaction. No `done_o` is issued.

**Latency**
- Request accepted at edge 0 → `app_en` = 1 in cycle 1.
- Command accepted at edge a → read data valid at edge v → `done_o` high in cycle v+1. So `done_o` comes one cycle after valid, and `rdata_o` is valid from the same cycle as `done_o`.
- Write with `app_rdy` = `app_wdf_rdy` = 1 → `done_o` in cycle 2, `ready_o` in cycle 3.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure

- Shared header `mig_defs.vh` holds:
  - `MIG_CMD_WRITE` = 3'b000 and `MIG_CMD_READ` = 3'b001;
  - the state encodings;
  - the line-offset width (6).
- Single flat module with no sub-module. The timeout counter is $clog2(`TIMEOUT`) bits, inline.

## Test plan

1. **Read:** `addr_i` = 0x0000_0040, `app_rdy` = 1, model returns valid 12 cycles after acceptance → `app_addr` = 0x0000008, `app_cmd` = 1, `done_o` one cycle after valid, `rdata_o` = model data, `err_o` = 0.
2. **Write with mask:** `be_i` = 0x000F, `wdata_i` = 0xA5 pattern → `app_wdf_mask` = 0xFFF0, `app_cmd` = 0. Readback shows only bytes 0–3 changed.
3. **Write with data before command:** `app_rdy` held 0 for 5 cycles, `app_wdf_rdy` = 1 → `app_wdf_wren` drops after 1 cycle, `app_en` stays high 6 cycles, single `done_o`.
4. **Timeout:** `TIMEOUT` = 16, valid never arrives → `done_o` = 1 and `err_o` = 1, 16 cycles after acceptance. `rdata_o` is unchanged and the next `req_i` is accepted.
5. **Back-to-back and spurious inputs:**
   - `req_i` held high continuously → `app_en` low for at least 2 cycles between commands.
   - Stray `app_rd_data_valid` in IDLE → ignored.
6. **Reset mid-read:** `rst_ni` = 0 in RD_WAIT → `app_en` = 0 and `ready_o` = 1 asynchronously, no `done_o`.

Source files
------------

// File: rtl/mig_user_bridge_pkg.sv
// Shared constants and types for the cache-line to MIG user-interface bridge.
package mig_user_bridge_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 128;
    localparam int unsigned APP_ADDR_W         = 28;
    localparam int unsigned LINE_OFS_W         = 6;
    localparam int unsigned APP_CMD_W          = 3;

    localparam logic [APP_CMD_W-1:0] MIG_CMD_WRITE = 3'b000;
    localparam logic [APP_CMD_W-1:0] MIG_CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMD     = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    typedef struct packed {
        logic [APP_CMD_W-1:0]  cmd;
        logic [APP_ADDR_W-1:0] addr;
    } app_cmd_t;

endpackage

// File: rtl/mig_user_bridge.sv
// Single-outstanding cache-line bridge onto the MIG user interface.
// Command and write data handshakes complete independently; reads time out.
module mig_user_bridge
    import mig_user_bridge_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [31:0]             addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    output logic                    ready_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic                    app_en,
    output logic [27:0]             app_addr,
    output logic [2:0]              app_cmd,
    output logic [DATA_WIDTH-1:0]   app_wdf_data,
    output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
    output logic                    app_wdf_wren,
    output logic                    app_wdf_end,
    input  logic                    app_rdy,
    input  logic                    app_wdf_rdy,
    input  logic [DATA_WIDTH-1:0]   app_rd_data,
    input  logic                    app_rd_data_valid,
    input  logic                    app_rd_data_end,
    output logic                    app_sr_req,
    output logic                    app_ref_req,
    output logic                    app_zq_req
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e                state_q, state_d;
    app_cmd_t              cmd_q, cmd_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]       mask_q, mask_d;
    logic                  we_q, we_d;
    logic                  cmd_acc_q, cmd_acc_d;
    logic                  dat_acc_q, dat_acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  app_en_q, app_en_d;
    logic                  wdf_wren_q, wdf_wren_d;

    // Line offset, bit 31 and the read-burst end marker carry no information here.
    logic unused_ok;
    assign unused_ok = ^{app_rd_data_end, addr_i[31], addr_i[LINE_OFS_W-1:0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            wdata_q    <= '0;
            mask_q     <= '0;
            we_q       <= 1'b0;
            cmd_acc_q  <= 1'b0;
            dat_acc_q  <= 1'b0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            app_en_q   <= 1'b0;
            wdf_wren_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            wdata_q    <= wdata_d;
            mask_q     <= mask_d;
            we_q       <= we_d;
            cmd_acc_q  <= cmd_acc_d;
            dat_acc_q  <= dat_acc_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            err_q      <= err_d;
            app_en_q   <= app_en_d;
            wdf_wren_q <= wdf_wren_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        wdata_d   = wdata_q;
        mask_d    = mask_q;
        we_d      = we_q;
        cmd_acc_d = cmd_acc_q;
        dat_acc_d = dat_acc_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    we_d       = we_i;
                    cmd_d.cmd  = we_i ? MIG_CMD_WRITE : MIG_CMD_READ;
                    cmd_d.addr = {addr_i[30:LINE_OFS_W], 3'b000};
                    wdata_d    = wdata_i;
                    mask_d     = ~be_i;
                    cmd_acc_d  = 1'b0;
                    // Reads have no data phase, so that flag starts satisfied.
                    dat_acc_d  = ~we_i;
                    state_d    = ST_CMD;
                end
            end
            ST_CMD: begin
                if (app_en_q && app_rdy) begin
                    cmd_acc_d = 1'b1;
                end
                if (wdf_wren_q && app_wdf_rdy) begin
                    dat_acc_d = 1'b1;
                end
                if (cmd_acc_d && dat_acc_d) begin
                    state_d = we_q ? ST_DONE : ST_RD_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RD_WAIT: begin
                // Valid beats a coincident timeout.
                if (app_rd_data_valid) begin
                    rdata_d = app_rd_data;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so nothing is combinational.
        ready_d    = (state_d == ST_IDLE);
        done_d     = (state_d == ST_DONE);
        app_en_d   = (state_d == ST_CMD) && !cmd_acc_d;
        wdf_wren_d = (state_d == ST_CMD) && !dat_acc_d;
    end

    assign ready_o      = ready_q;
    assign rdata_o      = rdata_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign app_en       = app_en_q;
    assign app_addr     = cmd_q.addr;
    assign app_cmd      = cmd_q.cmd;
    assign app_wdf_data = wdata_q;
    assign app_wdf_mask = mask_q;
    assign app_wdf_wren = wdf_wren_q;
    assign app_wdf_end  = wdf_wren_q;
    assign app_sr_req   = 1'b0;
    assign app_ref_req  = 1'b0;
    assign app_zq_req   = 1'b0;

endmodule

// File: tb/tb_mig_user_bridge.sv
// Scoreboard bench for mig_user_bridge against a small MIG user-interface model.
module tb_mig_user_bridge;

    localparam int DW = 128;
    localparam int BW = 16;

    logic          clk;
    logic          rst_n;
    logic          req;
    logic          we;
    logic [31:0]   addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    logic          ready;
    logic [DW-1:0] rdata;
    logic          done;
    logic          err;
    logic          app_en;
    logic [27:0]   app_addr;
    logic [2:0]    app_cmd;
    logic [DW-1:0] app_wdf_data;
    logic [BW-1:0] app_wdf_mask;
    logic          app_wdf_wren;
    logic          app_wdf_end;
    logic          app_rdy;
    logic          app_wdf_rdy;
    logic [DW-1:0] app_rd_data;
    logic          app_rd_data_valid;
    logic          app_rd_data_end;
    logic          app_sr_req;
    logic          app_ref_req;
    logic          app_zq_req;

    mig_user_bridge #(.DATA_WIDTH(DW), .TIMEOUT(16)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be),
        .ready_o(ready), .rdata_o(rdata), .done_o(done), .err_o(err),
        .app_en(app_en), .app_addr(app_addr), .app_cmd(app_cmd),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data_end(app_rd_data_end),
        .app_sr_req(app_sr_req), .app_ref_req(app_ref_req), .app_zq_req(app_zq_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [27:0] addr; logic [2:0] cmd; } cmd_exp_t;
    typedef struct { logic [DW-1:0] data; logic [BW-1:0] mask; } dat_exp_t;
    typedef struct { logic err; logic [DW-1:0] rdata; int lat; int en_cyc; int wren_cyc; } done_exp_t;

    cmd_exp_t  exp_cmd [$];
    dat_exp_t  exp_dat [$];
    done_exp_t exp_done[$];
    string         dq_name[$];
    logic [DW-1:0] dq_act [$];
    logic [DW-1:0] dq_exp [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rd_lat   = 0;
    int stray_cnt = 0;

    localparam logic [DW-1:0] D1 = 128'hCAFE0040_CAFE0041_CAFE0042_CAFE0043;
    localparam logic [DW-1:0] D2 = {{12{8'h11}}, {4{8'hA5}}};
    localparam logic [DW-1:0] D3 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [DW-1:0] D5 = {4{32'h5A5A0F0F}};

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Direct checks from the stimulus process are queued and counted by the monitor.
    task automatic dchk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        dq_name.push_back(name);
        dq_act.push_back(act);
        dq_exp.push_back(exp);
    endtask

    // MIG user-interface model: memory, read latency, stray valid injection.
    logic [DW-1:0] mem [logic [27:0]];
    int            rd_cnt = 0;
    logic [27:0]   rd_addr;
    logic [27:0]   wa;
    logic [DW-1:0] wd;
    logic [BW-1:0] wm;
    bit            wa_have = 0, wd_have = 0, preloaded = 0;
    int            stray_seen = 0;

    always @(negedge clk) begin
        logic [DW-1:0] line;
        if (!preloaded) begin
            mem[28'h8]  = D1;
            mem[28'h10] = {16{8'h11}};
            preloaded   = 1;
        end
        app_rd_data_valid = 1'b0;
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                app_rd_data_valid = 1'b1;
                app_rd_data = mem.exists(rd_addr) ? mem[rd_addr] : '0;
            end
        end
        if (stray_seen != stray_cnt) begin
            stray_seen = stray_cnt;
            app_rd_data_valid = 1'b1;
            app_rd_data = {4{32'hDEADBEEF}};
        end
        if (!rst_n) begin
            rd_cnt = 0; wa_have = 0; wd_have = 0;
        end else begin
            if (app_en && app_rdy) begin
                if (app_cmd == 3'b001) begin
                    if (rd_lat > 0) begin rd_cnt = rd_lat; rd_addr = app_addr; end
                end else begin
                    wa = app_addr; wa_have = 1;
                end
            end
            if (app_wdf_wren && app_wdf_rdy) begin
                wd = app_wdf_data; wm = app_wdf_mask; wd_have = 1;
            end
            if (wa_have && wd_have) begin
                line = mem.exists(wa) ? mem[wa] : '0;
                for (int i = 0; i < BW; i++)
                    if (!wm[i]) line[i*8 +: 8] = wd[i*8 +: 8];
                mem[wa] = line;
                wa_have = 0; wd_have = 0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a handshake or completion.
    int en_cyc = 0, wren_cyc = 0, low_run = 0, acc_cyc = 0;
    bit had_cmd = 0, prev_en = 0;

    always @(negedge clk) begin
        cmd_exp_t  ce;
        dat_exp_t  de;
        done_exp_t xe;
        while (dq_name.size() > 0)
            chk(dq_name.pop_front(), dq_act.pop_front(), dq_exp.pop_front());
        if (!rst_n) begin
            en_cyc = 0; wren_cyc = 0; low_run = 0; had_cmd = 0; prev_en = 0;
        end else begin
            if (app_en) en_cyc++;
            if (app_wdf_wren) wren_cyc++;
            if (app_en && !prev_en && had_cmd) chk("cmd_gap_ge2", DW'(low_run >= 2), DW'(1));
            if (app_en) begin low_run = 0; had_cmd = 1; end else low_run++;
            prev_en = app_en;
            if (app_en && app_rdy) begin
                acc_cyc = cyc + 1;
                if (exp_cmd.size() == 0) chk("unexpected_cmd", DW'(app_addr), '1);
                else begin
                    ce = exp_cmd.pop_front();
                    chk("app_addr", DW'(app_addr), DW'(ce.addr));
                    chk("app_cmd", DW'(app_cmd), DW'(ce.cmd));
                end
            end
            if (app_wdf_wren && app_wdf_rdy) begin
                if (exp_dat.size() == 0) chk("unexpected_wdata", app_wdf_data, '1);
                else begin
                    de = exp_dat.pop_front();
                    chk("app_wdf_data", app_wdf_data, de.data);
                    chk("app_wdf_mask", DW'(app_wdf_mask), DW'(de.mask));
                    chk("app_wdf_end", DW'(app_wdf_end), DW'(1));
                end
            end
            if (done) begin
                if (exp_done.size() == 0) chk("unexpected_done", DW'(done), DW'(0));
                else begin
                    xe = exp_done.pop_front();
                    chk("err_o", DW'(err), DW'(xe.err));
                    chk("rdata_o", rdata, xe.rdata);
                    if (xe.lat >= 0) chk("done_latency", DW'(cyc - acc_cyc), DW'(xe.lat));
                    chk("app_en_cycles", DW'(en_cyc), DW'(xe.en_cyc));
                    chk("wren_cycles", DW'(wren_cyc), DW'(xe.wren_cyc));
                end
                en_cyc = 0; wren_cyc = 0;
            end
        end
    end

    task automatic push_cmd(input logic [27:0] a, input logic [2:0] c);
        cmd_exp_t e; e.addr = a; e.cmd = c; exp_cmd.push_back(e);
    endtask

    task automatic push_dat(input logic [DW-1:0] d, input logic [BW-1:0] m);
        dat_exp_t e; e.data = d; e.mask = m; exp_dat.push_back(e);
    endtask

    task automatic push_done(input logic e_err, input logic [DW-1:0] d, input int lat,
                             input int en_c, input int wr_c);
        done_exp_t e;
        e.err = e_err; e.rdata = d; e.lat = lat; e.en_cyc = en_c; e.wren_cyc = wr_c;
        exp_done.push_back(e);
    endtask

    // Called just after a rising edge; returns one step after the accepting edge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [DW-1:0] d,
                         input logic [BW-1:0] b);
        int n = 0;
        while (!ready && n < 100) begin @(posedge clk); #1; n++; end
        if (!ready) dchk("ready_wait_timeout", DW'(ready), DW'(1));
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic wait_quiet();
        int n = 0;
        while (!(exp_done.size() == 0 && ready) && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) dchk("drain_timeout", DW'(exp_done.size()), DW'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data_end = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        dchk("rst_ready", DW'(ready), DW'(1));
        dchk("rst_app_en", DW'(app_en), DW'(0));
        dchk("rst_done_err", DW'({done, err, app_wdf_wren, app_wdf_end}), DW'(0));
        dchk("rst_rdata", rdata, '0);
        dchk("rst_app_addr", DW'(app_addr), DW'(0));
        dchk("tie_offs", DW'({app_sr_req, app_ref_req, app_zq_req}), DW'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Read with 12-cycle model latency.
        rd_lat = 12;
        push_cmd(28'h8, 3'b001);
        push_done(1'b0, D1, 12, 1, 0);
        issue(1'b0, 32'h0000_0040, '0, '0);
        wait_quiet();

        // Masked write, then readback of the merged line.
        push_cmd(28'h10, 3'b000);
        push_dat({16{8'hA5}}, 16'hFFF0);
        push_done(1'b0, D1, -1, 1, 1);
        issue(1'b1, 32'h0000_0080, {16{8'hA5}}, 16'h000F);
        dchk("wr_c1_en_wren", DW'({app_en, app_wdf_wren}), DW'(2'b11));
        @(posedge clk); #1;
        dchk("wr_c2_done_ready", DW'({done, ready}), DW'(2'b10));
        @(posedge clk); #1;
        dchk("wr_c3_done_ready", DW'({done, ready}), DW'(2'b01));
        wait_quiet();
        rd_lat = 5;
        push_cmd(28'h10, 3'b001);
        push_done(1'b0, D2, 5, 1, 0);
        issue(1'b0, 32'h0000_0080, '0, '0);
        wait_quiet();

        // Write data accepted long before the command; high bit and offset dropped.
        app_rdy = 1'b0;
        push_cmd(28'h240, 3'b000);
        push_dat(D3, 16'h0000);
        push_done(1'b0, D2, -1, 6, 1);
        issue(1'b1, 32'h8000_1234, D3, 16'hFFFF);
        repeat (5) @(posedge clk);
        #1;
        app_rdy = 1'b1;
        wait_quiet();

        // Read timeout, then a normal read is still accepted.
        rd_lat = 0;
        push_cmd(28'h8, 3'b001);
        push_done(1'b1, D2, 16, 1, 0);
        issue(1'b0, 32'h0000_0040, '0, '0);
        wait_quiet();
        rd_lat = 3;
        push_cmd(28'h8, 3'b001);
        push_done(1'b0, D1, 3, 1, 0);
        issue(1'b0, 32'h0000_0040, '0, '0);
        wait_quiet();

        // req_i held high: three writes at edges 0, 3 and 6.
        for (int i = 0; i < 3; i++) begin
            push_cmd(28'h38, 3'b000);
            push_dat(D5, 16'h0000);
            push_done(1'b0, D1, -1, 1, 1);
        end
        req = 1'b1; we = 1'b1; addr = 32'h0000_01C0; wdata = D5; be = 16'hFFFF;
        repeat (7) @(posedge clk);
        #1;
        req = 1'b0;
        wait_quiet();

        // Stray read-data valid while idle.
        stray_cnt++;
        repeat (3) @(posedge clk);
        #1;
        dchk("stray_rdata_held", rdata, D1);
        dchk("stray_idle_ready", DW'({ready, done}), DW'(2'b10));

        // Reset during RD_WAIT.
        rd_lat = 0;
        push_cmd(28'h8, 3'b001);
        issue(1'b0, 32'h0000_0040, '0, '0);
        repeat (3) @(posedge clk);
        #2;
        dchk("rdwait_not_ready", DW'(ready), DW'(0));
        rst_n = 1'b0;
        #1;
        dchk("rst_rdwait_en_ready_done", DW'({app_en, ready, done}), DW'(3'b010));
        #9;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset during CMD with both handshakes stalled.
        app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        issue(1'b1, 32'h0000_0040, D3, 16'hFFFF);
        dchk("cmd_stall_en_wren", DW'({app_en, app_wdf_wren}), DW'(2'b11));
        #1;
        rst_n = 1'b0;
        #1;
        dchk("rst_cmd_en_wren_ready", DW'({app_en, app_wdf_wren, ready}), DW'(3'b001));
        #9;
        rst_n = 1'b1;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        @(posedge clk); #1;

        // Recovery write after reset; rdata was cleared by reset.
        push_cmd(28'h20, 3'b000);
        push_dat(D5, 16'h0000);
        push_done(1'b0, '0, -1, 1, 1);
        issue(1'b1, 32'h0000_0100, D5, 16'hFFFF);
        wait_quiet();
        dchk("done_queue_empty", DW'(exp_done.size()), DW'(0));
        dchk("cmd_queue_empty", DW'(exp_cmd.size()), DW'(0));
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
